// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding,
// default operand width and the quotient returned on divide-by-zero.
package div_pkg;

  localparam int DIV_N_DEFAULT = 8;

  // Wide all-ones constant; users slice off the operand width they need.
  localparam logic [63:0] DIV_ZERO_Q = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    CMP   = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } div_state_t;

endpackage

// File: rtl/div_sub_cmp.sv
// Combinational unsigned compare-and-subtract used for each quotient bit
// decision: reports a >= b and the difference a - b.
module div_sub_cmp #(
  parameter int W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         ge_o,
  output logic [W-1:0] diff_o
);

  assign ge_o   = (a_i >= b_i);
  assign diff_o = a_i - b_i;

endmodule

// File: rtl/div_ctrl.sv
// Sequencer and compare/subtract stage of the restoring divider.
// One quotient bit is produced per SHIFT/CMP pair; results and the
// divide-by-zero flag are presented with a one-cycle done pulse.
// Build option: define DIV_SIGNED_EN for two's-complement operands
// (magnitudes taken at acceptance, signs fixed up in an extra FIX state).
module div_ctrl
  import div_pkg::*;
#(
  parameter int N  = DIV_N_DEFAULT,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividiendo,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] cociente,
  output logic [N-1:0] residuo,
  output logic         div_zero,
  output logic         cont,
  output logic         equal
);

  div_state_t    state_q;
  logic [N-1:0]  q_q;
  logic [N-1:0]  d_q;
  logic [N:0]    r_q;
  logic [N:0]    diff_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          cont_q;
  logic          equal_q;
  logic          div_zero_q;
  logic [N-1:0]  cociente_q;
  logic [N-1:0]  residuo_q;

  // Operand values loaded into Q and D on acceptance.
  logic [N-1:0]  a_load_d;
  logic [N-1:0]  b_load_d;

  // Shifted partial remainder/quotient and the per-bit decision.
  logic [N:0]    r_shift_d;
  logic [N-1:0]  q_shift_d;
  logic          cmp_ge_d;
  logic [N:0]    cmp_diff_d;
  logic [N-1:0]  q_cmp_d;
  logic [N:0]    r_cmp_d;
  logic          last_bit_d;

`ifdef DIV_SIGNED_EN
  logic          qneg_q;
  logic          rneg_q;
  logic [N-1:0]  q_fix_d;
  logic [N-1:0]  r_fix_d;

  // Work on magnitudes; the most-negative value maps onto itself, which
  // as an unsigned magnitude is exactly 2^(N-1).
  assign a_load_d = dividiendo[N-1] ? (~dividiendo + 1'b1) : dividiendo;
  assign b_load_d = divisor[N-1]    ? (~divisor + 1'b1)    : divisor;

  // Quotient sign follows the operand signs, remainder follows the dividend.
  assign q_fix_d = qneg_q ? (~q_q + 1'b1) : q_q;
  assign r_fix_d = rneg_q ? (~r_q[N-1:0] + 1'b1) : r_q[N-1:0];
`else
  assign a_load_d = dividiendo;
  assign b_load_d = divisor;
`endif

  // The bit leaving the top of Q enters the bottom of R; R is one bit
  // wider than the operands so the shift can never overflow.
  assign r_shift_d = {r_q[N-1:0], q_q[N-1]};
  assign q_shift_d = {q_q[N-2:0], 1'b0};

  div_sub_cmp #(
    .W(N + 1)
  ) u_sub_cmp (
    .a_i    (r_shift_d),
    .b_i    ({1'b0, d_q}),
    .ge_o   (cmp_ge_d),
    .diff_o (cmp_diff_d)
  );

  // The decision computed during SHIFT is held in equal_q/diff_q and
  // applied in CMP.
  assign q_cmp_d    = {q_q[N-1:1], equal_q};
  assign r_cmp_d    = equal_q ? diff_q : r_q;
  assign last_bit_d = (cnt_q == CW'(N - 1));

  // Control FSM with registered handshake strobes and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      q_q        <= '0;
      d_q        <= '0;
      r_q        <= '0;
      diff_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cont_q     <= 1'b0;
      equal_q    <= 1'b0;
      div_zero_q <= 1'b0;
      cociente_q <= '0;
      residuo_q  <= '0;
`ifdef DIV_SIGNED_EN
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
`endif
    end else begin
      done_q  <= 1'b0;
      cont_q  <= 1'b0;
      equal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            q_q    <= a_load_d;
            d_q    <= b_load_d;
            r_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
`ifdef DIV_SIGNED_EN
            qneg_q <= dividiendo[N-1] ^ divisor[N-1];
            rneg_q <= dividiendo[N-1];
`endif
            if (divisor == '0) begin
              // Skip the iterations and report the fixed divide-by-zero result.
              state_q    <= DONE;
              done_q     <= 1'b1;
              cociente_q <= DIV_ZERO_Q[N-1:0];
              residuo_q  <= dividiendo;
              div_zero_q <= 1'b1;
            end else begin
              state_q <= SHIFT;
              cont_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          r_q     <= r_shift_d;
          q_q     <= q_shift_d;
          diff_q  <= cmp_diff_d;
          equal_q <= cmp_ge_d;
          state_q <= CMP;
        end
        CMP: begin
          q_q   <= q_cmp_d;
          r_q   <= r_cmp_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_bit_d) begin
`ifdef DIV_SIGNED_EN
            state_q <= FIX;
`else
            state_q    <= DONE;
            done_q     <= 1'b1;
            cociente_q <= q_cmp_d;
            residuo_q  <= r_cmp_d[N-1:0];
            div_zero_q <= 1'b0;
`endif
          end else begin
            state_q <= SHIFT;
            cont_q  <= 1'b1;
          end
        end
`ifdef DIV_SIGNED_EN
        FIX: begin
          state_q    <= DONE;
          done_q     <= 1'b1;
          cociente_q <= q_fix_d;
          residuo_q  <= r_fix_d;
          div_zero_q <= 1'b0;
        end
`endif
        DONE: begin
          // start is deliberately not sampled here.
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign cont     = cont_q;
  assign equal    = equal_q;
  assign div_zero = div_zero_q;
  assign cociente = cociente_q;
  assign residuo  = residuo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: stimulus pushes hand-computed results,
// a monitor pops and checks them on every done pulse (value, latency,
// busy, number of shift pulses and the compare-result pattern).
module tb_div_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividiendo = 8'h00;
  logic [7:0] divisor = 8'h00;
  logic       busy;
  logic       done;
  logic [7:0] cociente;
  logic [7:0] residuo;
  logic       div_zero;
  logic       cont;
  logic       equal;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

`ifdef DIV_SIGNED_EN
  localparam int LAT = 18;
  localparam logic [7:0] NOM_Q = 8'hF6, NOM_R = 8'hFD, NOM_EQ = 8'h0A;
  localparam logic [7:0] FF1_EQ = 8'h01;
`else
  localparam int LAT = 17;
  localparam logic [7:0] NOM_Q = 8'd40, NOM_R = 8'd3, NOM_EQ = 8'h28;
  localparam logic [7:0] FF1_EQ = 8'hFF;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] coc;
    logic [7:0] res;
    logic       dz;
    int         issue;
    int         lat;
    int         ncont;
    logic [7:0] eqpat;
  } exp_t;

  exp_t sb[$];

  div_ctrl #(
    .N  (8),
    .CW (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividiendo (dividiendo),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .cociente   (cociente),
    .residuo    (residuo),
    .div_zero   (div_zero),
    .cont       (cont),
    .equal      (equal)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: accumulate shift pulses and compare results, check on done.
  initial begin
    int         ncont_acc = 0;
    logic [7:0] eq_acc = 8'h00;
    logic       prev_cont = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (prev_cont) eq_acc = {eq_acc[6:0], equal};
      if (cont) ncont_acc = ncont_acc + 1;
      prev_cont = cont;
      if (done) begin
        if (sb.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL unexpected_done actual=1 required=0 cociente=0x%0h", cociente);
        end else begin
          e = sb.pop_front();
          $display("txn %0d / %0d : cociente=0x%0h residuo=0x%0h div_zero=%0d lat=%0d cont=%0d",
                   e.a, e.b, cociente, residuo, div_zero, cyc - e.issue, ncont_acc);
          chk("cociente", int'(cociente), int'(e.coc));
          chk("residuo", int'(residuo), int'(e.res));
          chk("div_zero", int'(div_zero), int'(e.dz));
          chk("latency", cyc - e.issue, e.lat);
          chk("busy_at_done", int'(busy), 1);
          chk("cont_pulses", ncont_acc, e.ncont);
          chk("equal_pattern", int'(eq_acc), int'(e.eqpat));
        end
        ncont_acc = 0;
        eq_acc = 8'h00;
      end else if (!busy) begin
        ncont_acc = 0;
        eq_acc = 8'h00;
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic push,
                       input logic [7:0] ecoc, input logic [7:0] eres, input logic edz,
                       input int elat, input int encont, input logic [7:0] eeq,
                       output int icyc);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    dividiendo = a;
    divisor = b;
    icyc = cyc;
    if (push) begin
      e.a = a; e.b = b; e.coc = ecoc; e.res = eres; e.dz = edz;
      e.issue = cyc; e.lat = elat; e.ncont = encont; e.eqpat = eeq;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    dividiendo = 8'hA5;
    divisor = 8'h3C;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("pending_results", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_cociente"}, int'(cociente), 0);
    chk({tag, "_residuo"}, int'(residuo), 0);
    chk({tag, "_div_zero"}, int'(div_zero), 0);
    chk({tag, "_cont"}, int'(cont), 0);
    chk({tag, "_equal"}, int'(equal), 0);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Nominal, then results must hold while idle.
    issue(8'd203, 8'd5, 1'b1, NOM_Q, NOM_R, 1'b0, LAT, 8, NOM_EQ, k);
    drain(60);
    repeat (3) @(negedge clk);
    chk("hold_cociente", int'(cociente), int'(NOM_Q));
    chk("hold_residuo", int'(residuo), int'(NOM_R));

    // Divide by zero.
    issue(8'h5A, 8'h00, 1'b1, 8'hFF, 8'h5A, 1'b1, 1, 0, 8'h00, k);
    drain(60);

    // Edge operands.
    issue(8'hFF, 8'h01, 1'b1, 8'hFF, 8'h00, 1'b0, LAT, 8, FF1_EQ, k);
    drain(60);
    issue(8'd7, 8'd9, 1'b1, 8'd0, 8'd7, 1'b0, LAT, 8, 8'h00, k);
    drain(60);
    issue(8'd0, 8'd3, 1'b1, 8'd0, 8'd0, 1'b0, LAT, 8, 8'h00, k);
    drain(60);

    // Handshake: starts at cycle 3 and in the DONE cycle are ignored,
    // a start in the following idle cycle is accepted.
    issue(8'd203, 8'd5, 1'b1, NOM_Q, NOM_R, 1'b0, LAT, 8, NOM_EQ, k);
    while (cyc < k + 3) @(negedge clk);
    start = 1'b1; dividiendo = 8'h10; divisor = 8'h02;
    chk("busy_cycle3", int'(busy), 1);
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + LAT) @(negedge clk);
    start = 1'b1; dividiendo = 8'h11; divisor = 8'h03;
    @(negedge clk);
    dividiendo = 8'd100; divisor = 8'd7;
    begin
      exp_t e;
      e.a = 8'd100; e.b = 8'd7; e.coc = 8'd14; e.res = 8'd2; e.dz = 1'b0;
      e.issue = cyc; e.lat = LAT; e.ncont = 8; e.eqpat = 8'h0E;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    drain(100);

    // Reset mid-operation: no done pulse, outputs cleared, then a fresh op.
    issue(8'd203, 8'd5, 1'b0, 8'h00, 8'h00, 1'b0, 0, 0, 8'h00, k);
    while (cyc < k + 6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    repeat (25) @(negedge clk);
    issue(8'd100, 8'd7, 1'b1, 8'd14, 8'd2, 1'b0, LAT, 8, 8'h0E, k);
    drain(60);

`ifdef DIV_SIGNED_EN
    issue(8'h9C, 8'd7, 1'b1, 8'hF2, 8'hFE, 1'b0, LAT, 8, 8'h0E, k);
    drain(60);
    issue(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, LAT, 8, 8'h80, k);
    drain(60);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
